// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command/data sequencer between a byte-level SPI slave and a
// register bank. The first byte of every CS frame is a command (bit7 = read,
// low bits = start address); following bytes are written to, or read from,
// consecutive register addresses.
// Optional frame watchdog: define SPI_REG_CTRL_TIMEOUT_EN to abort frames that
// sit TIMEOUT_CYC cycles without a byte.
module spi_reg_ctrl #(
   parameter int ADDR_W      = 7,
   parameter int AUTO_INC    = 1,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              clk_25m,
   input  logic              rst_n,
   input  logic              cs_start,
   input  logic              cs_end,
   input  logic              spi_rx_en,
   input  logic [7:0]        receive_byte,
   input  logic              spi_tx_en,
   output logic [7:0]        send_byte,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err
);

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [ADDR_W-1:0] ADDR_STEP = (AUTO_INC != 0) ? ADDR_W'(1) : '0;

   typedef enum logic [2:0] {IDLE, CMD, WR, RD_FETCH, RD} state_t;

   state_t            state, state_nx;
   logic [2:0]        rx_pipe, tx_pipe;
   logic              rx_stb, tx_stb;
   logic              late_flag, late_nx;
   logic              got_cmd, got_nx;
   logic              inc_pend, inc_nx;
   logic              to_hit;
   logic [7:0]        send_nx, wdata_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic              we_nx, re_nx, done_nx, err_nx;

   // Two-flop synchronisers plus one history flop for rising-edge detection
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         rx_pipe <= '0;
         tx_pipe <= '0;
      end else begin
         rx_pipe <= {rx_pipe[1:0], spi_rx_en};
         tx_pipe <= {tx_pipe[1:0], spi_tx_en};
      end
   end

   assign rx_stb = rx_pipe[1] & ~rx_pipe[2];
   assign tx_stb = tx_pipe[1] & ~tx_pipe[2];
   assign busy   = (state != IDLE);

`ifdef SPI_REG_CTRL_TIMEOUT_EN
   logic [12:0] to_cnt;

   // Idle watchdog: counts cycles since the last byte while a frame is open
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n)
         to_cnt <= '0;
      else if (state == IDLE || rx_stb || cs_start)
         to_cnt <= '0;
      else if (!to_hit)
         to_cnt <= to_cnt + 13'd1;
   end

   assign to_hit = (state != IDLE) && (to_cnt == 13'(TIMEOUT_CYC));
`else
   // Without the watchdog the timeout parameter has no consumer; keep it referenced.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
   assign to_hit = 1'b0;
`endif

   // State register and all registered outputs
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         send_byte  <= 8'h00;
         reg_addr   <= '0;
         reg_wdata  <= 8'h00;
         reg_we     <= 1'b0;
         reg_re     <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         late_flag  <= 1'b0;
         got_cmd    <= 1'b0;
         inc_pend   <= 1'b0;
      end else begin
         state      <= state_nx;
         send_byte  <= send_nx;
         reg_addr   <= addr_nx;
         reg_wdata  <= wdata_nx;
         reg_we     <= we_nx;
         reg_re     <= re_nx;
         frame_done <= done_nx;
         frame_err  <= err_nx;
         late_flag  <= late_nx;
         got_cmd    <= got_nx;
         inc_pend   <= inc_nx;
      end
   end

   // Next-state and output decode; byte handling first, frame boundaries override
   always_comb begin
      state_nx = state;
      send_nx  = send_byte;
      addr_nx  = reg_addr;
      wdata_nx = reg_wdata;
      we_nx    = 1'b0;
      re_nx    = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      late_nx  = late_flag;
      got_nx   = got_cmd;
      inc_nx   = 1'b0;

      // Post-write address advance lands the cycle after the write strobe
      if (inc_pend)
         addr_nx = reg_addr + ADDR_STEP;

      case (state)
         IDLE: begin
            if (cs_start) begin
               state_nx = CMD;
               send_nx  = SYNC_BYTE;
               late_nx  = 1'b0;
               got_nx   = 1'b0;
            end
         end
         CMD: begin
            if (rx_stb) begin
               addr_nx = receive_byte[ADDR_W-1:0];
               got_nx  = 1'b1;
               if (receive_byte[7]) begin
                  re_nx    = 1'b1;
                  state_nx = RD_FETCH;
               end else begin
                  state_nx = WR;
               end
            end
         end
         WR: begin
            if (rx_stb) begin
               wdata_nx = receive_byte;
               we_nx    = 1'b1;
               inc_nx   = 1'b1;
            end
         end
         RD_FETCH: begin
            // Entered together with the read strobe; data is captured once the
            // strobe has dropped, i.e. the cycle the bank presents reg_rdata.
            if (tx_stb)
               late_nx = 1'b1;
            if (!reg_re) begin
               send_nx  = reg_rdata;
               state_nx = RD;
            end
         end
         RD: begin
            if (rx_stb) begin
               addr_nx  = reg_addr + ADDR_STEP;
               re_nx    = 1'b1;
               state_nx = RD_FETCH;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (state != IDLE) begin
         if (cs_start) begin
            // Missed cs_end: report and decode a fresh command
            err_nx   = 1'b1;
            state_nx = CMD;
            send_nx  = SYNC_BYTE;
            late_nx  = 1'b0;
            got_nx   = 1'b0;
         end else if (cs_end) begin
            state_nx = IDLE;
            send_nx  = SYNC_BYTE;
            if (got_nx && !late_nx)
               done_nx = 1'b1;
            else
               err_nx = 1'b1;
         end else if (to_hit) begin
            state_nx = IDLE;
            send_nx  = SYNC_BYTE;
            err_nx   = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: a behavioural register bank plus a scoreboard of
// expected write/read strobes and frame-end pulses.
module tb_spi_reg_ctrl;

   localparam int ADDR_W = 7;

   logic              clk_25m = 1'b0;
   logic              rst_n = 1'b0;
   logic              cs_start = 1'b0;
   logic              cs_end = 1'b0;
   logic              spi_rx_en = 1'b0;
   logic [7:0]        receive_byte = 8'h00;
   logic              spi_tx_en = 1'b0;
   logic [7:0]        send_byte;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_wdata;
   logic              reg_we;
   logic              reg_re;
   logic [7:0]        reg_rdata;
   logic              busy;
   logic              frame_done;
   logic              frame_err;

   logic [7:0]  mem [0:127];
   logic [15:0] exp_we [$];
   logic [7:0]  exp_re [$];
   int          exp_evt [$];
   int          n_cmp = 0;
   int          n_bad = 0;

   spi_reg_ctrl #(.ADDR_W(ADDR_W), .AUTO_INC(1), .TIMEOUT_CYC(64)) dut (
      .clk_25m(clk_25m), .rst_n(rst_n), .cs_start(cs_start), .cs_end(cs_end),
      .spi_rx_en(spi_rx_en), .receive_byte(receive_byte), .spi_tx_en(spi_tx_en),
      .send_byte(send_byte), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   always #20 clk_25m = ~clk_25m;

   // Register bank: synchronous write, read data valid the cycle after reg_re
   always @(posedge clk_25m) begin
      if (reg_we) mem[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= mem[reg_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: pops the scoreboard whenever the DUT issues a strobe or pulse
   always @(negedge clk_25m) begin
      if (rst_n) begin
         if (reg_we) begin
            if (exp_we.size() == 0) check("we_extra", 1, 0);
            else begin
               logic [15:0] e;
               e = exp_we.pop_front();
               check("we_addr", {25'd0, reg_addr}, {24'd0, e[15:8]});
               check("we_data", {24'd0, reg_wdata}, {24'd0, e[7:0]});
            end
         end
         if (reg_re) begin
            if (exp_re.size() == 0) check("re_extra", 1, 0);
            else check("re_addr", {25'd0, reg_addr}, {24'd0, exp_re.pop_front()});
         end
         if (frame_done) begin
            if (exp_evt.size() == 0) check("evt_extra_done", 1, 0);
            else check("frame_evt", 1, exp_evt.pop_front());
         end
         if (frame_err) begin
            if (exp_evt.size() == 0) check("evt_extra_err", 2, 0);
            else check("frame_evt", 2, exp_evt.pop_front());
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk_25m); cs_start = 1'b1;
      @(negedge clk_25m); cs_start = 1'b0;
      repeat (4) @(negedge clk_25m);
   endtask

   task automatic pulse_end();
      @(negedge clk_25m); cs_end = 1'b1;
      @(negedge clk_25m); cs_end = 1'b0;
      repeat (4) @(negedge clk_25m);
   endtask

   // One SPI byte: the slave loads send_byte at byte start, then reports the received byte
   task automatic spi_byte(input logic [7:0] b, input logic [7:0] tx_exp);
      @(negedge clk_25m);
      check("tx_byte", {24'd0, send_byte}, {24'd0, tx_exp});
      spi_tx_en = 1'b1;
      receive_byte = b;
      repeat (6) @(negedge clk_25m);
      spi_rx_en = 1'b1;
      repeat (6) @(negedge clk_25m);
      spi_rx_en = 1'b0;
      spi_tx_en = 1'b0;
      repeat (6) @(negedge clk_25m);
   endtask

   // Last byte whose receive strobe coincides with the cs_end pulse
   task automatic spi_byte_end(input logic [7:0] b, input logic [7:0] tx_exp);
      @(negedge clk_25m);
      check("tx_byte", {24'd0, send_byte}, {24'd0, tx_exp});
      spi_tx_en = 1'b1;
      receive_byte = b;
      repeat (6) @(negedge clk_25m);
      spi_rx_en = 1'b1;
      @(posedge clk_25m);
      @(posedge clk_25m);
      @(negedge clk_25m); cs_end = 1'b1;
      @(negedge clk_25m); cs_end = 1'b0;
      repeat (4) @(negedge clk_25m);
      spi_rx_en = 1'b0;
      spi_tx_en = 1'b0;
      repeat (6) @(negedge clk_25m);
   endtask

   task automatic drain();
      repeat (4) @(negedge clk_25m);
      check("we_left", exp_we.size(), 0);
      check("re_left", exp_re.size(), 0);
      check("evt_left", exp_evt.size(), 0);
      check("busy_idle", {31'd0, busy}, 0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'(i ^ 8'h5A);
      mem[8'h10] = 8'hAB;
      mem[8'h11] = 8'hCD;

      // Reset state
      #5;
      check("rst_send", {24'd0, send_byte}, 0);
      check("rst_addr", {25'd0, reg_addr}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_strb", {28'd0, reg_we, reg_re, frame_done, frame_err}, 0);
      repeat (3) @(negedge clk_25m);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_25m);

      // Write burst at 5,6,7
      exp_we.push_back({8'h05, 8'h11});
      exp_we.push_back({8'h06, 8'h22});
      exp_we.push_back({8'h07, 8'h33});
      exp_evt.push_back(1);
      pulse_start();
      check("busy_frame", {31'd0, busy}, 1);
      spi_byte(8'h05, 8'hA5);
      spi_byte(8'h11, 8'hA5);
      spi_byte(8'h22, 8'hA5);
      spi_byte(8'h33, 8'hA5);
      pulse_end();
      drain();

      // Read burst from 0x10
      exp_re.push_back(8'h10);
      exp_re.push_back(8'h11);
      exp_re.push_back(8'h12);
      exp_evt.push_back(1);
      pulse_start();
      spi_byte(8'h90, 8'hA5);
      spi_byte(8'h00, 8'hAB);
      spi_byte(8'h00, 8'hCD);
      pulse_end();
      check("send_after", {24'd0, send_byte}, 32'hA5);
      drain();

      // Address wrap 127 -> 0
      exp_we.push_back({8'h7F, 8'h12});
      exp_we.push_back({8'h00, 8'h34});
      exp_evt.push_back(1);
      pulse_start();
      spi_byte(8'h7F, 8'hA5);
      spi_byte(8'h12, 8'hA5);
      spi_byte(8'h34, 8'hA5);
      pulse_end();
      drain();

      // Empty frame
      exp_evt.push_back(2);
      pulse_start();
      pulse_end();
      drain();

      // cs_start during WR, then a fresh command
      exp_we.push_back({8'h03, 8'h44});
      exp_evt.push_back(2);
      pulse_start();
      spi_byte(8'h03, 8'hA5);
      spi_byte(8'h44, 8'hA5);
      pulse_start();
      exp_we.push_back({8'h20, 8'h55});
      exp_evt.push_back(1);
      spi_byte(8'h20, 8'hA5);
      spi_byte(8'h55, 8'hA5);
      pulse_end();
      drain();

      // Receive strobe coinciding with cs_end: write still lands
      exp_we.push_back({8'h30, 8'h66});
      exp_evt.push_back(1);
      pulse_start();
      spi_byte(8'h30, 8'hA5);
      spi_byte_end(8'h66, 8'hA5);
      drain();

      // Reset mid-read
      exp_re.push_back(8'h10);
      pulse_start();
      spi_byte(8'h90, 8'hA5);
      @(negedge clk_25m);
      rst_n = 1'b0;
      #1;
      check("mid_rst_send", {24'd0, send_byte}, 0);
      check("mid_rst_addr", {25'd0, reg_addr}, 0);
      check("mid_rst_busy", {31'd0, busy}, 0);
      check("mid_rst_strb", {28'd0, reg_we, reg_re, frame_done, frame_err}, 0);
      repeat (3) @(negedge clk_25m);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_25m);
      exp_we.push_back({8'h08, 8'h77});
      exp_evt.push_back(1);
      pulse_start();
      spi_byte(8'h08, 8'hA5);
      spi_byte(8'h77, 8'hA5);
      pulse_end();
      drain();

`ifdef SPI_REG_CTRL_TIMEOUT_EN
      // Watchdog abort; the late cs_end must stay silent
      exp_evt.push_back(2);
      pulse_start();
      spi_byte(8'h01, 8'hA5);
      for (int i = 0; i < 200 && exp_evt.size() != 0; i++) @(negedge clk_25m);
      check("to_busy", {31'd0, busy}, 0);
      pulse_end();
      repeat (8) @(negedge clk_25m);
      drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time limit
   initial begin
      #4000000;
      $display("FAIL timeout: observed still running expected finished");
      $fatal(1);
   end

endmodule
